framebuffer_monochrome: RTL and testbench

1-bit-per-pixel framebuffer for the OLED path, H_PIXELS × V_PIXELS, stored row-major as bytes (H_PIXELS/8 bytes per row). The drawing logic writes 8-pixel horizontal spans at any x (bit-aligned or not). The display scan-out reads either 8-pixel horizontal spans or 8-pixel vertical columns, the latter for page-style OLED controllers. Storage is a register array so that reset clears it instantly.

---
 rtl/fb_pkg.sv | 11 +
 rtl/fb_column_gather.sv | 22 ++
 rtl/framebuffer_monochrome.sv | 66 ++++++
 tb/tb_framebuffer_monochrome.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: default geometry and byte addressing for the monochrome framebuffer.
package fb_pkg;
  localparam int DEF_H_PIXELS = 128;
  localparam int DEF_V_PIXELS = 64;
  localparam int BYTES_PER_ROW = DEF_H_PIXELS / 8;
  localparam int FB_BYTES = BYTES_PER_ROW * DEF_V_PIXELS;
  localparam int FB_ADDR_W = $clog2(FB_BYTES);
  function automatic int byte_idx(input int x, input int y, input int bpr = BYTES_PER_ROW);
    return y * bpr + x / 8;
  endfunction
endpackage

// File: rtl/fb_column_gather.sv
// fb_column_gather: collects one pixel column of 8 rows starting at y, MSB = top row.
module fb_column_gather
  import fb_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_PIXELS = DEF_V_PIXELS
) (
  input  logic [7:0] mem [H_PIXELS / 8 * V_PIXELS],
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] col
);
  localparam int BPR = H_PIXELS / 8;
  localparam int AW = $clog2(BPR * V_PIXELS);
  for (genvar k = 0; k < 8; k++) begin : g_row
    logic in_r;
    logic [AW-1:0] idx;
    assign in_r = int'(y) + k < V_PIXELS && int'(x) < H_PIXELS;
    assign idx = in_r ? AW'(byte_idx(int'(x), int'(y) + k, BPR)) : '0;
    assign col[7-k] = in_r & mem[idx][~x[2:0]];
  end
endmodule

// File: rtl/framebuffer_monochrome.sv
// framebuffer_monochrome: 1bpp register framebuffer with 8-pixel span writes and span reads.
// Define COLUMN_READ_EN to enable r_mode column reads for page-style OLED controllers.
module framebuffer_monochrome
  import fb_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_PIXELS = DEF_V_PIXELS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] w_xpos,
  input  logic [7:0] w_ypos,
  input  logic [7:0] din,
  input  logic       re,
  input  logic [7:0] r_xpos,
  input  logic [7:0] r_ypos,
  input  logic       r_mode,
  output logic [7:0] dout
);
  localparam int BPR = H_PIXELS / 8;
  localparam int BYTES = BPR * V_PIXELS;
  localparam int AW = $clog2(BYTES);
  logic [7:0] mem [BYTES];
  logic [2:0] w_off, r_off;
  logic w_ok, w2_ok, r_ok, r2_ok;
  logic [AW-1:0] w_idx, r_idx;
  logic [7:0] w_mask, rl, rr, hspan, rdata;
  assign w_off = w_xpos[2:0];
  assign w_ok = we && int'(w_ypos) < V_PIXELS && int'(w_xpos) < H_PIXELS;
  // the right-hand byte exists only for unaligned spans that stay inside the row
  assign w2_ok = w_ok && w_off != 3'd0 && int'(w_xpos[7:3]) + 1 < BPR;
  assign w_idx = w_ok ? AW'(byte_idx(int'(w_xpos), int'(w_ypos), BPR)) : '0;
  assign w_mask = 8'hFF >> w_off;
  assign r_off = r_xpos[2:0];
  assign r_ok = int'(r_ypos) < V_PIXELS && int'(r_xpos) < H_PIXELS;
  assign r2_ok = r_ok && r_off != 3'd0 && int'(r_xpos[7:3]) + 1 < BPR;
  assign r_idx = r_ok ? AW'(byte_idx(int'(r_xpos), int'(r_ypos), BPR)) : '0;
  assign rl = r_ok ? mem[r_idx] : '0;
  assign rr = r2_ok ? mem[r_idx + AW'(1)] : '0;
  assign hspan = 8'(({rl, rr} << r_off) >> 8);
`ifdef COLUMN_READ_EN
  logic [7:0] col;
  fb_column_gather #(.H_PIXELS(H_PIXELS), .V_PIXELS(V_PIXELS)) u_col (
    .mem(mem),
    .x(r_xpos),
    .y(r_ypos),
    .col(col)
  );
  assign rdata = r_mode ? col : hspan;
`else
  logic unused_r_mode;
  assign unused_r_mode = r_mode;
  assign rdata = hspan;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BYTES; i++) mem[i] <= '0;
      dout <= '0;
    end else begin
      if (w_ok) mem[w_idx] <= (mem[w_idx] & ~w_mask) | (din >> w_off);
      if (w2_ok) mem[w_idx + AW'(1)] <= (mem[w_idx + AW'(1)] & w_mask) | (din << (4'd8 - 4'(w_off)));
      if (re) dout <= rdata;
    end
  end
endmodule

// File: tb/tb_framebuffer_monochrome.sv
// tb_framebuffer_monochrome: table-driven directed checks plus an asynchronous mid-stream reset sequence.
module tb_framebuffer_monochrome;
`ifdef COLUMN_READ_EN
  localparam bit COL = 1'b1;
`else
  localparam bit COL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0, r_mode = 1'b0;
  logic [7:0] w_xpos = '0, w_ypos = '0, din = '0, r_xpos = '0, r_ypos = '0;
  logic [7:0] dout;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  framebuffer_monochrome dut (
    .clk(clk), .rst(rst), .we(we), .w_xpos(w_xpos), .w_ypos(w_ypos), .din(din),
    .re(re), .r_xpos(r_xpos), .r_ypos(r_ypos), .r_mode(r_mode), .dout(dout)
  );

  typedef struct {
    bit rst, we;
    logic [7:0] wx, wy, d;
    bit re;
    logic [7:0] rx, ry;
    bit md, chk;
    logic [7:0] eh, ec;
  } vec_t;

  vec_t v[$];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: dout=%02h expected %02h", nm, act, exp);
    end
  endtask

  function automatic vec_t w(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
    vec_t t = '{default: 0};
    t.we = 1; t.wx = x; t.wy = y; t.d = d;
    return t;
  endfunction

  function automatic vec_t r(input logic [7:0] x, input logic [7:0] y, input logic [7:0] e);
    vec_t t = '{default: 0};
    t.re = 1; t.rx = x; t.ry = y; t.chk = 1; t.eh = e; t.ec = e;
    return t;
  endfunction

  function automatic vec_t c(input logic [7:0] x, input logic [7:0] y, input logic [7:0] eh, input logic [7:0] ec);
    vec_t t = r(x, y, eh);
    t.md = 1; t.ec = ec;
    return t;
  endfunction

  function automatic vec_t hold(input logic [7:0] e);
    vec_t t = '{default: 0};
    t.chk = 1; t.eh = e; t.ec = e;
    return t;
  endfunction

  function automatic vec_t rs();
    vec_t t = '{default: 0};
    t.rst = 1; t.chk = 1;
    return t;
  endfunction

  function automatic vec_t rw(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d, input logic [7:0] e);
    vec_t t = r(x, y, e);
    t.we = 1; t.wx = x; t.wy = y; t.d = d;
    return t;
  endfunction

  initial begin
    logic [7:0] rows [8] = '{8'hCC, 8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hAA, 8'hF0, 8'h0F};
    logic [7:0] ech [8] = '{8'hCC, 8'h98, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00, 8'h00};
    logic [7:0] ecc [8] = '{8'hEE, 8'hAA, 8'h66, 8'h22, 8'hDD, 8'h99, 8'h55, 8'h11};
    v.push_back(r(0, 0, 8'h00));
    v.push_back(r(8, 1, 8'h00));
    v.push_back(w(0, 0, 8'hF0));
    v.push_back(w(8, 0, 8'hAA));
    v.push_back(w(16, 0, 8'hCC));
    v.push_back(w(0, 1, 8'hFF));
    v.push_back(w(8, 1, 8'h01));
    v.push_back(r(0, 0, 8'hF0));
    v.push_back(r(8, 0, 8'hAA));
    v.push_back(r(16, 0, 8'hCC));
    v.push_back(r(0, 1, 8'hFF));
    v.push_back(r(8, 1, 8'h01));
    v.push_back(hold(8'h01));
    v.push_back(r(4, 0, 8'h0A));
    v.push_back(r(12, 0, 8'hAC));
    v.push_back(rs());
    v.push_back(r(0, 0, 8'h00));
    v.push_back(w(4, 0, 8'hF3));
    v.push_back(r(0, 0, 8'h0F));
    v.push_back(r(8, 0, 8'h30));
    v.push_back(r(4, 0, 8'hF3));
    v.push_back(w(12, 2, 8'hAA));
    v.push_back(r(8, 2, 8'h0A));
    v.push_back(r(16, 2, 8'hA0));
    v.push_back(r(12, 2, 8'hAA));
    v.push_back(rw(40, 5, 8'h3C, 8'h00));
    v.push_back(r(40, 5, 8'h3C));
    v.push_back(w(0, 1, 8'h5A));
    v.push_back(w(124, 0, 8'hFF));
    v.push_back(r(120, 0, 8'h0F));
    v.push_back(r(124, 0, 8'hF0));
    v.push_back(r(0, 1, 8'h5A));
    v.push_back(r(200, 0, 8'h00));
    v.push_back(w(0, 64, 8'hFF));
    v.push_back(w(200, 0, 8'hFF));
    v.push_back(r(0, 0, 8'h0F));
    v.push_back(r(0, 64, 8'h00));
    v.push_back(w(0, 3, 8'hFF));
    v.push_back(w(8, 3, 8'hFF));
    v.push_back(w(2, 3, 8'h00));
    v.push_back(r(0, 3, 8'hC0));
    v.push_back(r(8, 3, 8'h3F));
    v.push_back(rs());
    for (int k = 0; k < 8; k++) v.push_back(w(0, 8'(k), rows[k]));
    for (int x = 0; x < 8; x++) v.push_back(c(8'(x), 0, ech[x], ecc[x]));
    v.push_back(c(3, 3, 8'h78, 8'h10));
    for (int k = 60; k < 64; k++) v.push_back(w(0, 8'(k), 8'hFF));
    v.push_back(c(0, 60, 8'hFF, 8'hF0));
    v.push_back(c(0, 62, 8'hFF, 8'hC0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", dout, 8'h00);
    rst = 1'b0;
    foreach (v[i]) begin
      rst = v[i].rst; we = v[i].we; w_xpos = v[i].wx; w_ypos = v[i].wy; din = v[i].d;
      re = v[i].re; r_xpos = v[i].rx; r_ypos = v[i].ry; r_mode = v[i].md;
      @(posedge clk);
      #1;
      rst = 1'b0; we = 1'b0; re = 1'b0; r_mode = 1'b0;
      if (v[i].chk) check($sformatf("vec%0d(%0d,%0d,m%0d)", i, v[i].rx, v[i].ry, v[i].md), dout,
                          (v[i].md && COL) ? v[i].ec : v[i].eh);
    end

    we = 1'b1; w_xpos = 0; w_ypos = 0; din = 8'hFF;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b1; r_xpos = 0; r_ypos = 0;
    @(posedge clk);
    #1;
    check("pre_rst_read", dout, 8'hFF);
    we = 1'b1; w_xpos = 8; w_ypos = 0; din = 8'hFF; re = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_dout", dout, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0; re = 1'b1; r_xpos = 0; r_ypos = 0;
    @(posedge clk);
    #1;
    check("rst_cleared_0_0", dout, 8'h00);
    r_xpos = 8;
    @(posedge clk);
    #1;
    check("rst_aborted_write_8_0", dout, 8'h00);
    re = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
